rv32_uart_tx_mmio: RTL and testbench

- Memory-mapped UART transmitter that acts as one MMIO slave on the core data bus.
- Consumes the data request broadcast by the top level. Returns one mmio_request_done / mmio_data pair, wired into one slot of the top's MMIO arrays.
- Buffers written bytes in a small FIFO and serialises them as 8N1 frames on a tx pin at a programmable bit rate.

---
 rtl/rv32_uart_tx_mmio.sv | 268 ++++++++++++++++++++++++++
 tb/tb_rv32_uart_tx_mmio.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the rv32 data bus.
// Register window: +0x0 DATA (W), +0x4 STATUS (R), +0x8 CLKDIV (R/W).
// Written bytes are queued in a small FIFO and shifted out LSB first.

package rv32_uart_tx_pkg;
    typedef logic [31:0] rv32_word;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_op_t;

    typedef struct packed {
        mem_op_t  op;
        rv32_word addr;
        rv32_word data;
    } memory_request_t;
endpackage

// Transmit FSM states:
//   state    | meaning
//   ST_IDLE  | line high, pops the next byte when the FIFO has one
//   ST_START | start bit (low) for CLKDIV cycles
//   ST_DATA  | eight data bits, LSB first, CLKDIV cycles each
//   ST_STOP  | stop bit (high) for CLKDIV cycles
module rv32_uart_tx_mmio
    import rv32_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic            clk,
    input  logic            reset,
    input  memory_request_t data_request,
    output logic            request_done,
    output rv32_word        data,
    output logic            tx
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CLKDIV = 2'd2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Bus side
    logic        hit;
    logic        serve;
    logic        pending;
    rv32_word    pend_addr;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_off;
    logic [15:0] req_wdata;
    rv32_word    status_word;
    rv32_word    rd_word;
    logic [15:0] clkdiv;
    logic        overflow;
    logic        unused_bits;

    // FIFO
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push_req;
    logic        push_ok;
    logic        pop;

    // Transmitter
    logic [1:0]  state;
    logic [1:0]  state_n;
    logic [7:0]  shift;
    logic [7:0]  shift_n;
    logic [2:0]  bit_cnt;
    logic [2:0]  bit_n;
    logic [15:0] baud_cnt;
    logic [15:0] baud_n;
    logic        tx_n;

    assign unused_bits = ^data_request.data[31:16];

    // Offset 0xC lies inside the decoded window but is not a register, so it never answers.
    assign hit = (data_request.op != MEM_NONE)
              && (data_request.addr[31:4] == BASE_ADDR[31:4])
              && (data_request.addr[1:0] == 2'b00)
              && (data_request.addr[3:2] != 2'b11);

    // A held request is served only once; a new address or a return to NONE re-arms it.
    assign serve = hit && !(pending && (data_request.addr == pend_addr));

    assign request_done = req_valid;

    assign count      = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign push_req = req_valid && req_write && (req_off == OFF_DATA);
    assign pop      = (state == ST_IDLE) && !fifo_empty;
    // The pop frees a slot first, so a push on a full FIFO still lands when a pop coincides.
    assign push_ok  = push_req && (!fifo_full || pop);

    // Track the currently presented request so a held one is not served again.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= 1'b0;
            pend_addr <= '0;
        end else begin
            pending   <= hit;
            pend_addr <= data_request.addr;
        end
    end

    // Register a served request; its effects and the done pulse happen one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_valid <= 1'b0;
            req_write <= 1'b0;
            req_off   <= 2'b00;
            req_wdata <= '0;
        end else begin
            req_valid <= serve;
            req_write <= (data_request.op == MEM_WRITE);
            req_off   <= data_request.addr[3:2];
            req_wdata <= data_request.data[15:0];
        end
    end

    // Assemble the STATUS word and the read mux.
    always_comb begin
        status_word        = '0;
        status_word[4:0]   = 5'(count);
        status_word[8]     = fifo_full;
        status_word[9]     = fifo_empty;
        status_word[10]    = (state != ST_IDLE);
        status_word[11]    = overflow;
        rd_word            = '0;
        case (req_off)
            OFF_STATUS: rd_word = status_word;
            OFF_CLKDIV: rd_word = {16'h0000, clkdiv};
            default:    rd_word = '0;
        endcase
    end

    // Register writes, sticky overflow and read-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            clkdiv   <= DEFAULT_DIV;
            overflow <= 1'b0;
            data     <= '0;
        end else begin
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end else if (req_valid && !req_write && (req_off == OFF_STATUS)) begin
                overflow <= 1'b0;
            end
            if (req_valid && req_write && (req_off == OFF_CLKDIV)) begin
                clkdiv <= (req_wdata < 16'd2) ? 16'd2 : req_wdata;
            end
            if (req_valid && !req_write) begin
                data <= rd_word;
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= req_wdata[7:0];
        end
    end

    // FIFO pointers wrap naturally through the extra MSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Next-state logic; the baud down-counter reloads from CLKDIV at every bit boundary.
    always_comb begin
        state_n = state;
        shift_n = shift;
        bit_n   = bit_cnt;
        baud_n  = baud_cnt;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_n = ST_START;
                    shift_n = mem[rd_ptr[AW-1:0]];
                    bit_n   = 3'd0;
                    baud_n  = clkdiv - 16'd1;
                end
            end
            ST_START: begin
                if (baud_cnt == 16'd0) begin
                    state_n = ST_DATA;
                    baud_n  = clkdiv - 16'd1;
                end else begin
                    baud_n = baud_cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_cnt == 16'd0) begin
                    baud_n  = clkdiv - 16'd1;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_n = ST_STOP;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_n = baud_cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_cnt == 16'd0) begin
                    state_n = ST_IDLE;
                end else begin
                    baud_n = baud_cnt - 16'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (state_n == ST_START) begin
            tx_n = 1'b0;
        end else if (state_n == ST_DATA) begin
            tx_n = shift_n[0];
        end else begin
            tx_n = 1'b1;
        end
    end

    // Transmitter registers; tx is registered so the pin never glitches on state changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            bit_cnt  <= bit_n;
            baud_cnt <= baud_n;
            tx       <= tx_n;
        end
    end

endmodule

// File: tb/tb_rv32_uart_tx_mmio.sv
// Self-checking bench for rv32_uart_tx_mmio: register access table, served-read
// scoreboard, serial frame checks, FIFO overflow and mid-frame reset.
module tb_rv32_uart_tx_mmio;
    import rv32_uart_tx_pkg::*;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic            clk = 1'b0;
    logic            reset;
    memory_request_t req;
    logic            request_done;
    rv32_word        data;
    logic            tx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_read;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        mem_op_t     op;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_done;
        logic [31:0] exp_data;
        string       name;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    rv32_uart_tx_mmio #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (8),
        .DEFAULT_DIV(16'd868)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_request(req),
        .request_done(request_done),
        .data        (data),
        .tx          (tx)
    );

    // Scoreboard monitor: every done pulse pops one expectation; reads are checked
    // the cycle after done and again one cycle later (held).
    bit          chk_due  = 1'b0;
    bit          chk_hold = 1'b0;
    logic [31:0] due_val;
    logic [31:0] hold_val;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_hold) begin
                checks++;
                if (data !== hold_val) begin
                    errors++;
                    $display("FAIL data_held: got %h want %h", data, hold_val);
                end
                chk_hold = 1'b0;
            end
            if (chk_due) begin
                checks++;
                if (data !== due_val) begin
                    errors++;
                    $display("FAIL read_data: got %h want %h", data, due_val);
                end
                chk_hold = 1'b1;
                hold_val = due_val;
                chk_due  = 1'b0;
            end
            if (request_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 want done=0");
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_read) begin
                        chk_due = 1'b1;
                        due_val = e.val;
                    end
                end
            end
        end
    end

    task automatic do_req(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit exp_done, input logic [31:0] exp_data, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_done) begin
            e.is_read = (op == MEM_READ);
            e.val     = exp_data;
            exp_q.push_back(e);
        end
        req.op   = op;
        req.addr = addr;
        req.data = wdata;
        @(posedge clk);
        #1;
        req.op = MEM_NONE;
        @(negedge clk);
        checks++;
        if (request_done !== exp_done) begin
            errors++;
            $display("FAIL %s done: got %b want %b", name, request_done, exp_done);
        end
    endtask

    // Checks one 8N1 frame cycle by cycle. chained: the call starts on the idle cycle
    // that must separate this frame from the previous one.
    task automatic check_frame(input logic [7:0] b, input int div, input bit chained, input string name);
        bit   ok;
        logic expv;
        logic badv;
        int   n;
        if (chained) begin
            checks++;
            if (tx !== 1'b1) begin
                errors++;
                $display("FAIL %s idle_gap: tx=%b want 1", name, tx);
            end
            @(negedge clk);
            checks++;
            if (tx !== 1'b0) begin
                errors++;
                $display("FAIL %s start_after_gap: tx=%b want 0", name, tx);
            end
        end else begin
            n = 0;
            while (tx !== 1'b0 && n < 3000) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (tx !== 1'b0) begin
                errors++;
                $display("FAIL %s start_timeout: tx=%b want 0", name, tx);
            end
        end
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      expv = 1'b0;
            else if (k == 9) expv = 1'b1;
            else             expv = b[k-1];
            ok   = 1'b1;
            badv = expv;
            for (int c = 0; c < div; c++) begin
                if (tx !== expv && ok) begin
                    ok   = 1'b0;
                    badv = tx;
                end
                @(negedge clk);
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s bit%0d: tx=%b want %b for %0d cycles", name, k, badv, expv, div);
            end
        end
    endtask

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int   n;
        bit   ok;
        exp_t e;

        tbl.push_back('{MEM_READ,  BASE + 32'h4,  32'h0,         1'b1, 32'h0000_0200, "rst_status"});
        tbl.push_back('{MEM_READ,  BASE + 32'h8,  32'h0,         1'b1, 32'h0000_0364, "rst_clkdiv"});
        tbl.push_back('{MEM_WRITE, BASE + 32'h8,  32'h0,         1'b1, 32'h0,         "div_wr0"});
        tbl.push_back('{MEM_READ,  BASE + 32'h8,  32'h0,         1'b1, 32'h0000_0002, "div_clamp0"});
        tbl.push_back('{MEM_WRITE, BASE + 32'h8,  32'h1,         1'b1, 32'h0,         "div_wr1"});
        tbl.push_back('{MEM_READ,  BASE + 32'h8,  32'h0,         1'b1, 32'h0000_0002, "div_clamp1"});
        tbl.push_back('{MEM_WRITE, BASE + 32'h8,  32'hFFFF_0010, 1'b1, 32'h0,         "div_wr_upper"});
        tbl.push_back('{MEM_READ,  BASE + 32'h8,  32'h0,         1'b1, 32'h0000_0010, "div_upper"});
        tbl.push_back('{MEM_READ,  BASE + 32'hC,  32'h0,         1'b0, 32'h0,         "rd_off_c"});
        tbl.push_back('{MEM_WRITE, BASE + 32'hC,  32'h41,        1'b0, 32'h0,         "wr_off_c"});
        tbl.push_back('{MEM_READ,  BASE + 32'h2,  32'h0,         1'b0, 32'h0,         "rd_misaligned"});
        tbl.push_back('{MEM_WRITE, BASE + 32'h1,  32'h42,        1'b0, 32'h0,         "wr_misaligned"});
        tbl.push_back('{MEM_READ,  BASE + 32'h10, 32'h0,         1'b0, 32'h0,         "rd_outside"});
        tbl.push_back('{MEM_WRITE, BASE + 32'h10, 32'h43,        1'b0, 32'h0,         "wr_outside"});
        tbl.push_back('{MEM_WRITE, BASE - 32'h4,  32'h44,        1'b0, 32'h0,         "wr_below"});
        tbl.push_back('{MEM_NONE,  BASE,          32'h45,        1'b0, 32'h0,         "op_none"});
        tbl.push_back('{MEM_READ,  BASE + 32'h4,  32'h0,         1'b1, 32'h0000_0200, "status_after_ignored"});
        tbl.push_back('{MEM_WRITE, BASE + 32'h8,  32'h4,         1'b1, 32'h0,         "div_wr4"});
        tbl.push_back('{MEM_READ,  BASE + 32'h8,  32'h0,         1'b1, 32'h0000_0004, "div_rd4"});

        req.op   = MEM_NONE;
        req.addr = '0;
        req.data = '0;
        reset    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b want 1", tx); end
        checks++;
        if (request_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", request_done); end
        checks++;
        if (data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", data); end

        foreach (tbl[i]) begin
            do_req(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].exp_done, tbl[i].exp_data, tbl[i].name);
        end

        // Held read: one done only while the same request stays on the bus.
        @(posedge clk);
        #1;
        e.is_read = 1'b1;
        e.val     = 32'h0000_0004;
        exp_q.push_back(e);
        req.op   = MEM_READ;
        req.addr = BASE + 32'h8;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (request_done === 1'b1) n++;
        end
        req.op = MEM_NONE;
        repeat (3) begin
            @(negedge clk);
            if (request_done === 1'b1) n++;
        end
        checks++;
        if (n != 1) begin errors++; $display("FAIL held_request: got %0d done pulses want 1", n); end

        // Single frame at CLKDIV=4 with STATUS busy mid-frame and idle afterwards.
        do_req(MEM_WRITE, BASE + 32'h8, 32'h4, 1'b1, 32'h0, "div4_a5");
        fork
            check_frame(8'hA5, 4, 1'b0, "frame_a5");
            begin
                do_req(MEM_WRITE, BASE, 32'h0000_00A5, 1'b1, 32'h0, "wr_a5");
                repeat (12) @(posedge clk);
                do_req(MEM_READ, BASE + 32'h4, 32'h0, 1'b1, 32'h0000_0600, "status_busy");
            end
        join
        do_req(MEM_READ, BASE + 32'h4, 32'h0, 1'b1, 32'h0000_0200, "status_idle");

        // Fill while the first frame runs: byte 1 is popped, bytes 2..9 fill the FIFO,
        // byte 10 overflows.
        fork
            check_frame(8'h01, 4, 1'b0, "frame_01");
            begin
                for (int k = 1; k <= 10; k++) begin
                    do_req(MEM_WRITE, BASE, 32'(k), 1'b1, 32'h0, "wr_fill");
                end
                do_req(MEM_READ, BASE + 32'h4, 32'h0, 1'b1, 32'h0000_0D08, "status_overflow");
                do_req(MEM_READ, BASE + 32'h4, 32'h0, 1'b1, 32'h0000_0508, "status_ovf_cleared");
            end
        join
        for (int k = 2; k <= 9; k++) begin
            check_frame(8'(k), 4, 1'b1, "frame_chained");
        end
        do_req(MEM_READ, BASE + 32'h4, 32'h0, 1'b1, 32'h0000_0200, "status_drained");

        // Reset in the middle of a frame.
        do_req(MEM_WRITE, BASE, 32'h0, 1'b1, 32'h0, "wr_zero_a");
        do_req(MEM_WRITE, BASE, 32'h0, 1'b1, 32'h0, "wr_zero_b");
        repeat (12) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL mid_frame_low: tx=%b want 0", tx); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: tx=%b want 1", tx); end
        do_req(MEM_READ, BASE + 32'h4, 32'h0, 1'b1, 32'h0000_0200, "status_after_reset");
        do_req(MEM_READ, BASE + 32'h8, 32'h0, 1'b1, 32'h0000_0364, "clkdiv_after_reset");
        ok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (tx !== 1'b1) ok = 1'b0;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL tx_quiet_after_reset: tx went 0 want 1"); end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_done: got %0d outstanding want 0", exp_q.size());
        end
        finish_run();
    end

endmodule
